// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad BCD entry path.
// RANGE_SAT_EN (top module) selects saturating versus modulo-256 conversion.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_0    = 4'd0;
  localparam key_code_t KEY_1    = 4'd1;
  localparam key_code_t KEY_2    = 4'd2;
  localparam key_code_t KEY_3    = 4'd3;
  localparam key_code_t KEY_4    = 4'd4;
  localparam key_code_t KEY_5    = 4'd5;
  localparam key_code_t KEY_6    = 4'd6;
  localparam key_code_t KEY_7    = 4'd7;
  localparam key_code_t KEY_8    = 4'd8;
  localparam key_code_t KEY_9    = 4'd9;
  localparam key_code_t KEY_CLR  = 4'hA;
  localparam key_code_t KEY_BS   = 4'hB;
  localparam key_code_t KEY_ENT  = 4'hC;
  localparam key_code_t KEY_NONE = 4'hF;

  localparam logic [9:0] K100 = 10'd100;
  localparam logic [9:0] K10  = 10'd10;

  typedef struct packed {
    logic [3:0] centena;
    logic [3:0] decena;
    logic [3:0] unidad;
  } bcd_buf_t;

  // Row r (0 = top), column c (0 = leftmost); B, C and D carry no action.
  function automatic key_code_t keymap(input logic [1:0] r, input logic [1:0] c);
    key_code_t k;
    case ({r, c})
      4'h0: k = KEY_1;
      4'h1: k = KEY_2;
      4'h2: k = KEY_3;
      4'h3: k = KEY_CLR;
      4'h4: k = KEY_4;
      4'h5: k = KEY_5;
      4'h6: k = KEY_6;
      4'h8: k = KEY_7;
      4'h9: k = KEY_8;
      4'hA: k = KEY_9;
      4'hC: k = KEY_BS;
      4'hD: k = KEY_0;
      4'hE: k = KEY_ENT;
      default: k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/kp_scan.sv
// Keypad column scanner with row synchronizer, scan-tick divider and
// press/release debounce; emits one key event per physical press.
module kp_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DEB_TICKS = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_evt,
  output key_code_t  key_code
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEB_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_DONE = CW'(DEB_TICKS);

  logic [3:0]    row_meta, rs;
  logic [DW-1:0] div_cnt;
  logic          tick_c;

  kp_state_e     state, state_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt;
  logic [1:0]    lat_row, lat_row_nxt, lat_col, lat_col_nxt;
  logic [1:0]    low_row_c, col_idx_c;
  logic [3:0]    col_nxt;
  logic          evt_nxt;
  key_code_t     code_nxt;

  // Row synchronizer and free-running scan divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
      div_cnt  <= '0;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick_c = (div_cnt == DIV_LAST);

  // Lowest-index active row wins; column index decoded from the drive.
  always_comb begin
    low_row_c = 2'd3;
    if      (!rs[0]) low_row_c = 2'd0;
    else if (!rs[1]) low_row_c = 2'd1;
    else if (!rs[2]) low_row_c = 2'd2;
    col_idx_c = 2'd3;
    if      (!col[0]) col_idx_c = 2'd0;
    else if (!col[1]) col_idx_c = 2'd1;
    else if (!col[2]) col_idx_c = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SCAN;
      deb_cnt  <= '0;
      lat_row  <= '0;
      lat_col  <= '0;
      col      <= 4'b1110;
      key_evt  <= 1'b0;
      key_code <= KEY_NONE;
    end else begin
      state    <= state_nxt;
      deb_cnt  <= deb_nxt;
      lat_row  <= lat_row_nxt;
      lat_col  <= lat_col_nxt;
      col      <= col_nxt;
      key_evt  <= evt_nxt;
      key_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:     if (tick_c && rs != 4'hF) state_nxt = PRESS_DB;
      PRESS_DB: if (deb_cnt == DEB_DONE) state_nxt = HELD;
                else if (tick_c && rs[lat_row]) state_nxt = SCAN;
      HELD:     if (tick_c && rs == 4'hF) state_nxt = REL_DB;
      REL_DB:   if (deb_cnt == DEB_DONE) state_nxt = SCAN;
                else if (tick_c && rs != 4'hF) state_nxt = HELD;
      default:  state_nxt = SCAN;
    endcase
  end

  // Column drive, debounce count and key event for the next cycle.
  always_comb begin
    col_nxt     = col;
    deb_nxt     = deb_cnt;
    lat_row_nxt = lat_row;
    lat_col_nxt = lat_col;
    evt_nxt     = 1'b0;
    code_nxt    = key_code;
    case (state)
      SCAN: begin
        if (tick_c) begin
          if (rs == 4'hF) begin
            col_nxt = {col[2:0], col[3]};
          end else begin
            lat_row_nxt = low_row_c;
            lat_col_nxt = col_idx_c;
            deb_nxt     = CW'(1);
          end
        end
      end
      PRESS_DB: begin
        if (deb_cnt == DEB_DONE) begin
          evt_nxt  = 1'b1;
          code_nxt = keymap(lat_row, lat_col);
        end else if (tick_c && !rs[lat_row]) begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (tick_c && rs == 4'hF) deb_nxt = CW'(1);
      end
      REL_DB: begin
        if (deb_cnt != DEB_DONE && tick_c && rs == 4'hF) deb_nxt = deb_cnt + 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad entry: 3-digit BCD buffer driven by debounced key events, converted
// to an 8-bit operand on Enter. RANGE_SAT_EN saturates overflowing entries at 255.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DEB_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] unidad,
  output logic [3:0] decena,
  output logic [3:0] centena,
  output logic [1:0] ndig,
  output logic [7:0] value,
  output logic       valid,
  output logic       ovf
);

  logic      key_evt;
  key_code_t key_code;
  bcd_buf_t  bcd;
  logic [9:0] sum_c;
  logic [7:0] res_c;
  logic       ovf_c;

  kp_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_TICKS (DEB_TICKS)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  always_comb begin
    sum_c = 10'(bcd.centena) * K100 + 10'(bcd.decena) * K10 + 10'(bcd.unidad);
    ovf_c = (sum_c > 10'd255);
`ifdef RANGE_SAT_EN
    res_c = ovf_c ? 8'd255 : sum_c[7:0];
`else
    res_c = sum_c[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd   <= '0;
      ndig  <= 2'd0;
      value <= 8'd0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (key_evt) begin
        if (key_code <= KEY_9) begin
          if (ndig != 2'd3) begin
            bcd  <= '{centena: bcd.decena, decena: bcd.unidad, unidad: key_code};
            ndig <= ndig + 1'b1;
          end
        end else if (key_code == KEY_CLR) begin
          bcd  <= '0;
          ndig <= 2'd0;
        end else if (key_code == KEY_BS) begin
          if (ndig != 2'd0) begin
            bcd  <= '{centena: 4'd0, decena: bcd.centena, unidad: bcd.decena};
            ndig <= ndig - 1'b1;
          end
        end else if (key_code == KEY_ENT) begin
          value <= res_c;
          ovf   <= ovf_c;
          valid <= 1'b1;
          bcd   <= '0;
          ndig  <= 2'd0;
        end
      end
    end
  end

  assign unidad  = bcd.unidad;
  assign decena  = bcd.decena;
  assign centena = bcd.centena;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry: keypad model, per-scenario tasks, and a
// scoreboard of expected Enter results checked whenever valid pulses.
module tb_keypad_bcd_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row, col, unidad, decena, centena;
  logic [1:0] ndig;
  logic [7:0] value;
  logic       valid, ovf;

  logic       kdown  = 1'b0;
  logic       glitch = 1'b0;
  logic [1:0] kr = 2'd0, kc = 2'd0;

  typedef struct packed {
    logic [7:0] value;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;

`ifdef RANGE_SAT_EN
  localparam logic [7:0] OVF_VALUE = 8'd255;
`else
  localparam logic [7:0] OVF_VALUE = 8'd231;
`endif

  keypad_bcd_entry #(.SCAN_DIV(4), .DEB_TICKS(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .row     (row),
    .col     (col),
    .unidad  (unidad),
    .decena  (decena),
    .centena (centena),
    .ndig    (ndig),
    .value   (value),
    .valid   (valid),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Matrix model: the pressed key pulls its row low while its column is driven.
  assign row = (kdown && !glitch && col[kc] == 1'b0) ? ~(4'b0001 << kr) : 4'hF;

  // Scoreboard: every valid pulse must match the next queued Enter result.
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL valid_width: valid high on consecutive cycles, required 1-cycle pulse");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: value=%0d ovf=%0b, no Enter pending", value, ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (value !== e.value || ovf !== e.ovf) begin
          failures++;
          $display("FAIL enter_result: got value=%0d ovf=%0b, required value=%0d ovf=%0b",
                   value, ovf, e.value, e.ovf);
        end
      end
    end
    prev_valid <= valid;
  end

  task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int hold);
    @(negedge clk);
    kr = r; kc = c; kdown = 1'b1;
    repeat (hold) @(negedge clk);
    kdown = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic tap_key(input int k);
    case (k)
      1: press_key(2'd0, 2'd0, 48);   2: press_key(2'd0, 2'd1, 48);
      3: press_key(2'd0, 2'd2, 48);   4: press_key(2'd1, 2'd0, 48);
      5: press_key(2'd1, 2'd1, 48);   6: press_key(2'd1, 2'd2, 48);
      7: press_key(2'd2, 2'd0, 48);   8: press_key(2'd2, 2'd1, 48);
      9: press_key(2'd2, 2'd2, 48);   0: press_key(2'd3, 2'd1, 48);
      10: press_key(2'd0, 2'd3, 48);  // A clear
      11: press_key(2'd1, 2'd3, 48);  // B
      12: press_key(2'd3, 2'd0, 48);  // * backspace
      default: press_key(2'd3, 2'd2, 48);  // # enter
    endcase
  endtask

  task automatic enter(input logic [7:0] v, input logic o);
    exp_q.push_back('{value: v, ovf: o});
    tap_key(13);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks += 3;
    if (col !== 4'b1110) begin
      failures++; $display("FAIL reset_col: got %b, required 1110", col);
    end
    if ({centena, decena, unidad, ndig} !== 14'd0) begin
      failures++; $display("FAIL reset_buffer: got %h%h%h ndig=%0d, required 000 ndig=0",
                           centena, decena, unidad, ndig);
    end
    if ({value, valid, ovf} !== 10'd0) begin
      failures++; $display("FAIL reset_result: got value=%0d valid=%0b ovf=%0b, required 0/0/0",
                           value, valid, ovf);
    end
  endtask

  task automatic test_clear_ignore;
    tap_key(1);
    tap_key(11);
    checks++;
    if (ndig !== 2'd1 || unidad !== 4'd1) begin
      failures++; $display("FAIL b_ignored: got ndig=%0d unidad=%0d, required 1/1", ndig, unidad);
    end
    tap_key(10);
    checks++;
    if (ndig !== 2'd0 || {centena, decena, unidad} !== 12'h000) begin
      failures++; $display("FAIL clear: got ndig=%0d buf=%h%h%h, required 0 000",
                           ndig, centena, decena, unidad);
    end
    enter(8'd0, 1'b0);
    tap_key(12);
    checks++;
    if (ndig !== 2'd0 || {centena, decena, unidad} !== 12'h000) begin
      failures++; $display("FAIL bs_empty: got ndig=%0d buf=%h%h%h, required 0 000",
                           ndig, centena, decena, unidad);
    end
  endtask

  task automatic test_basic;
    tap_key(1); tap_key(2); tap_key(3);
    checks++;
    if ({centena, decena, unidad} !== 12'h123 || ndig !== 2'd3) begin
      failures++; $display("FAIL basic_buffer: got %h%h%h ndig=%0d, required 123 ndig=3",
                           centena, decena, unidad, ndig);
    end
    enter(8'd123, 1'b0);
    checks++;
    if ({centena, decena, unidad} !== 12'h000 || ndig !== 2'd0 || value !== 8'd123) begin
      failures++; $display("FAIL basic_after_enter: got buf=%h%h%h ndig=%0d value=%0d, required 000/0/123",
                           centena, decena, unidad, ndig, value);
    end
  endtask

  task automatic test_overflow;
    tap_key(9); tap_key(9); tap_key(9); tap_key(4);
    checks++;
    if ({centena, decena, unidad} !== 12'h999 || ndig !== 2'd3) begin
      failures++; $display("FAIL fourth_digit: got %h%h%h ndig=%0d, required 999 ndig=3",
                           centena, decena, unidad, ndig);
    end
    enter(OVF_VALUE, 1'b1);
    tap_key(5);
    tap_key(10);
    checks++;
    if (value !== OVF_VALUE || ovf !== 1'b1 || ndig !== 2'd0) begin
      failures++; $display("FAIL clear_keeps_result: got value=%0d ovf=%0b ndig=%0d, required %0d/1/0",
                           value, ovf, ndig, OVF_VALUE);
    end
  endtask

  task automatic test_backspace;
    tap_key(4); tap_key(5); tap_key(12);
    checks++;
    if ({centena, decena, unidad} !== 12'h004 || ndig !== 2'd1) begin
      failures++; $display("FAIL backspace: got %h%h%h ndig=%0d, required 004 ndig=1",
                           centena, decena, unidad, ndig);
    end
    tap_key(7);
    checks++;
    if ({centena, decena, unidad} !== 12'h047 || ndig !== 2'd2) begin
      failures++; $display("FAIL after_bs_digit: got %h%h%h ndig=%0d, required 047 ndig=2",
                           centena, decena, unidad, ndig);
    end
    enter(8'd47, 1'b0);
  endtask

  task automatic test_glitch;
    int n;
    n = 0;
    while (col !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    kr = 2'd1; kc = 2'd1; kdown = 1'b1;
    n = 0;
    while (col !== 4'b1101 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (col !== 4'b1101) begin
      failures++; $display("FAIL scan_timeout: col=%b, required 1101 within 100 cycles", col);
    end
    repeat (5) @(negedge clk);
    glitch = 1'b1;
    repeat (4) @(negedge clk);
    glitch = 1'b0;
    repeat (40) @(negedge clk);
    kdown = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (ndig !== 2'd1 || unidad !== 4'd5) begin
      failures++; $display("FAIL glitch_single: got ndig=%0d unidad=%0d, required 1/5", ndig, unidad);
    end
  endtask

  task automatic test_back_to_back;
    tap_key(10);
    press_key(2'd0, 2'd1, 80);
    tap_key(2);
    checks++;
    if (ndig !== 2'd2 || {decena, unidad} !== 8'h22) begin
      failures++; $display("FAIL long_hold: got ndig=%0d buf=%h%h, required 2 22", ndig, decena, unidad);
    end
  endtask

  task automatic test_reset_held;
    int n;
    tap_key(10);
    tap_key(2);
    @(negedge clk);
    kr = 2'd0; kc = 2'd1; kdown = 1'b1;
    n = 0;
    while (ndig !== 2'd2 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (ndig !== 2'd2) begin
      failures++; $display("FAIL held_timeout: ndig=%0d, required 2 within 200 cycles", ndig);
    end
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (col !== 4'b1110 || {centena, decena, unidad, ndig} !== 14'd0 ||
        {value, valid, ovf} !== 10'd0) begin
      failures++; $display("FAIL mid_reset: got col=%b buf=%h%h%h ndig=%0d value=%0d valid=%0b ovf=%0b, required 1110 000 0 0 0 0",
                           col, centena, decena, unidad, ndig, value, valid, ovf);
    end
    repeat (60) @(negedge clk);
    kdown = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (ndig !== 2'd1 || unidad !== 4'd2) begin
      failures++; $display("FAIL reheld_event: got ndig=%0d unidad=%0d, required 1/2", ndig, unidad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_clear_ignore();
    test_basic();
    test_overflow();
    test_backspace();
    test_glitch();
    test_back_to_back();
    test_reset_held();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL missing_valid: %0d Enter results never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
